// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB PWM LED driver: colour triple,
// full-scale constant and the squared-intensity gamma curve.
package rgb_pkg;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  typedef struct packed {
    logic [PWM_W-1:0] r;
    logic [PWM_W-1:0] g;
    logic [PWM_W-1:0] b;
  } rgb_t;

  // (d*d + PWM_MAX) >> PWM_W keeps 0 and full scale fixed and never rounds 1 down to 0
  function automatic logic [PWM_W-1:0] gamma(input logic [PWM_W-1:0] d);
    logic [2*PWM_W-1:0] dx;
    logic [2*PWM_W-1:0] sq;
    dx = {{PWM_W{1'b0}}, d};
    sq = dx * dx + {{PWM_W{1'b0}}, PWM_MAX};
    return sq[2*PWM_W-1:PWM_W];
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM output: compares the shared frame counter against this channel's
// duty and drives a registered active-low LED pin.
module rgb_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pin
);

  logic on_p0;

  assign on_p0 = (pwm_cnt < duty);

  // p0 -> p1: registered pin, dark while in reset
  always_ff @(posedge clk) begin
    if (rst) pin <= 1'b1;
    else     pin <= ~on_p0;
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver with a one-deep colour mailbox applied at frame
// boundaries. Define RGB_PWM_GAMMA_EN to square-law correct captured colours.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PRESCALE = 47,
  parameter int PWM_BITS = PWM_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [PWM_BITS-1:0] i_red,
  input  logic [PWM_BITS-1:0] i_green,
  input  logic [PWM_BITS-1:0] i_blue,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic                o_frame
);

  localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [PS_W-1:0]     presc;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                frame_edge;
  logic                xfer;
  logic                pend_full;
  rgb_t                cap;
  rgb_t                pend;
  rgb_t                duty_p0;

  assign tick       = (presc == PS_W'(PRESCALE));
  assign frame_edge = tick && (pwm_cnt == PWM_MAX);
  assign o_ready    = ~pend_full & ~rst;
  assign xfer       = i_valid & o_ready;

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)       pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

  always_comb begin
    cap = '0;
`ifdef RGB_PWM_GAMMA_EN
    cap.r = gamma(i_red);
    cap.g = gamma(i_green);
    cap.b = gamma(i_blue);
`else
    cap.r = i_red;
    cap.g = i_green;
    cap.b = i_blue;
`endif
  end

  // Mailbox data needs no reset: it is only consumed while pend_full is set
  always_ff @(posedge clk) begin
    if (xfer) pend <= cap;
  end

  // Pending only drains on a boundary and only fills while empty, so a
  // request landing on the boundary cycle waits for the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      duty_p0   <= '0;
      o_frame   <= 1'b0;
    end else begin
      o_frame <= frame_edge;
      if (frame_edge && pend_full) begin
        duty_p0   <= pend;
        pend_full <= 1'b0;
      end
      if (xfer) pend_full <= 1'b1;
    end
  end

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .duty    (duty_p0.r),
    .pin     (RGB_R)
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .duty    (duty_p0.g),
    .pin     (RGB_G)
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .duty    (duty_p0.b),
    .pin     (RGB_B)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver with PRESCALE = 0 (one PWM step per clk,
// 256-clk frames); expected low-times per frame are hand-computed.
module tb_rgb_pwm_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_red = '0;
  logic [7:0] i_green = '0;
  logic [7:0] i_blue = '0;
  logic       o_ready;
  logic       RGB_R;
  logic       RGB_G;
  logic       RGB_B;
  logic       o_frame;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(0), .PWM_BITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_red   (i_red),
    .i_green (i_green),
    .i_blue  (i_blue),
    .RGB_R   (RGB_R),
    .RGB_G   (RGB_G),
    .RGB_B   (RGB_B),
    .o_frame (o_frame)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge where o_frame is high; n = negedges consumed
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_frame !== 1'b1 && n < 300);
    check("frame_seen", o_frame, 1);
  endtask

  // Starting on an o_frame cycle, count low pin cycles over the next frame
  task automatic check_frame(input string tag, input int er, input int eg, input int eb);
    int lr, lg, lb;
    lr = 0; lg = 0; lb = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1 i_valid = 1'b0;
      @(negedge clk);
      if (RGB_R === 1'b0) lr++;
      if (RGB_G === 1'b0) lg++;
      if (RGB_B === 1'b0) lb++;
    end
    check({tag, "_r"}, lr, er);
    check({tag, "_g"}, lg, eg);
    check({tag, "_b"}, lb, eb);
    check({tag, "_period"}, o_frame, 1);
  endtask

  task automatic set_colour(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    i_valid = 1'b1;
    i_red   = r;
    i_green = g;
    i_blue  = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g_r;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", o_ready, 0);
    check("rst_frame", o_frame, 0);
    check("rst_pins", {RGB_R, RGB_G, RGB_B}, 3'b111);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", o_ready, 1);

    // Idle: dark pins, 256-clk frame period
    wait_frame(n);
    check("first_frame_delay", n, 256);
    check_frame("idle1", 0, 0, 0);
    check_frame("idle2", 0, 0, 0);
    check("idle_ready", o_ready, 1);

    // Full red
    set_colour(8'd255, 8'd0, 8'd0);
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    check("pend_full_ready", o_ready, 0);
    wait_frame(n);
    check_frame("red", 255, 0, 0);

    // Back-to-back requests: second stalls until the boundary
    set_colour(8'd64, 8'd128, 8'd0);
    @(posedge clk);
    #1 set_colour(8'd0, 8'd0, 8'd200);
    @(negedge clk);
    check("stall_ready", o_ready, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_ready !== 1'b1 && n < 300);
    check("stall_len", n, 255);
    check("stall_release_on_frame", o_frame, 1);
    check_frame("pair_f1", 64, 128, 0);
    check_frame("pair_f2", 0, 0, 200);
    check("pair_ready", o_ready, 1);

    // Request on the exact boundary cycle lands one frame later
    repeat (255) @(negedge clk);
    set_colour(8'd10, 8'd20, 8'd30);
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    check("bnd_frame", o_frame, 1);
    check("bnd_pending", o_ready, 0);
    check_frame("bnd_old", 0, 0, 200);
    check_frame("bnd_new", 10, 20, 30);

    // Mid-frame reset discards active and pending colours
    set_colour(8'd100, 8'd100, 8'd100);
    @(posedge clk);
    #1 i_valid = 1'b0;
    wait_frame(n);
    check_frame("hundred", 100, 100, 100);
    set_colour(8'd50, 8'd50, 8'd50);
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_lit", RGB_R, 0);
    check("mid_pending", o_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_pins", {RGB_R, RGB_G, RGB_B}, 3'b111);
    check("mid_rst_ready", o_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_after", o_ready, 1);
    check("mid_rst_pins_after", {RGB_R, RGB_G, RGB_B}, 3'b111);
    wait_frame(n);
    check("mid_rst_frame_delay", n, 256);
    check_frame("after_rst", 0, 0, 0);

    // Gamma curve (or pass-through in the default build)
`ifdef RGB_PWM_GAMMA_EN
    g_r = 64;
`else
    g_r = 128;
`endif
    set_colour(8'd128, 8'd1, 8'd255);
    @(posedge clk);
    #1 i_valid = 1'b0;
    wait_frame(n);
    check_frame("gamma", g_r, 1, 255);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
